// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared state encodings and Gray-to-binary helper for the Gray receive monitor
package gray_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCK = 2'b00,
        ST_LOCK   = 2'b01,
        ST_FAULT  = 2'b10
    } gray_state_t;

    localparam int G2B_W = 32;

    // Prefix-XOR from the MSB down; zero upper bits leave the lower result unchanged,
    // so callers of any width up to G2B_W zero-extend in and truncate out.
    function automatic logic [G2B_W-1:0] g2b(input logic [G2B_W-1:0] g);
        logic [G2B_W-1:0] b;
        b[G2B_W-1] = g[G2B_W-1];
        for (int i = G2B_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// rtl/gray2bin.sv - combinational Gray-to-binary decoder
module gray2bin
    import gray_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    logic [G2B_W-1:0] bin_full;

    assign bin_full = g2b(G2B_W'(gray));
    assign bin      = bin_full[WIDTH-1:0];

endmodule

// File: rtl/gray_rx_monitor.sv
// rtl/gray_rx_monitor.sv - Gray stream decoder with +1-step integrity check and wrap counting
module gray_rx_monitor
    import gray_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Valid,
    input  logic [WIDTH-1:0]  GrayIn,
    input  logic              Resync,
    output logic [WIDTH-1:0]  BinOut,
    output logic              Step,
    output logic [WRAP_W-1:0] Wraps,
    output logic              Overflow,
    output logic              Locked,
    output logic              Error
);

    gray_state_t       state, state_nxt;
    logic [WIDTH-1:0]  decoded;
    logic [WIDTH-1:0]  bin_inc;
    logic [WIDTH-1:0]  bin_nxt;
    logic              step_nxt;
    logic [WRAP_W-1:0] wraps_nxt;
    logic              ovf_nxt;

    gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
        .gray (GrayIn),
        .bin  (decoded)
    );

    assign bin_inc = BinOut + WIDTH'(1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= ST_UNLOCK;
            BinOut   <= '0;
            Step     <= 1'b0;
            Wraps    <= '0;
            Overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            BinOut   <= bin_nxt;
            Step     <= step_nxt;
            Wraps    <= wraps_nxt;
            Overflow <= ovf_nxt;
        end
    end

    // Locked/Error are pure decodes of the registered state, so they share its latency.
    assign Locked = (state == ST_LOCK);
    assign Error  = (state == ST_FAULT);

    always_comb begin
        state_nxt = state;
        bin_nxt   = BinOut;
        step_nxt  = 1'b0;
        wraps_nxt = Wraps;
        ovf_nxt   = Overflow;
        if (Resync) begin
            state_nxt = ST_UNLOCK;
        end else begin
            case (state)
                ST_UNLOCK: begin
                    if (Valid) begin
                        bin_nxt   = decoded;
                        state_nxt = ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (Valid && (decoded != BinOut)) begin
                        if (decoded == bin_inc) begin
                            bin_nxt  = decoded;
                            step_nxt = 1'b1;
                            if (BinOut == '1) begin
                                ovf_nxt = 1'b1;
                                if (Wraps != '1) begin
                                    wraps_nxt = Wraps + WRAP_W'(1);
                                end
                            end
                        end else begin
                            state_nxt = ST_FAULT;
                        end
                    end
                end
                ST_FAULT: begin
                    state_nxt = ST_FAULT;
                end
                default: begin
                    state_nxt = ST_UNLOCK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_rx_monitor.sv
// tb/tb_gray_rx_monitor.sv - scoreboard bench for gray_rx_monitor
module tb_gray_rx_monitor;

    logic       Clk;
    logic       Reset;
    logic       Valid;
    logic [2:0] GrayIn;
    logic       Resync;
    logic [2:0] BinOut;
    logic       Step;
    logic [3:0] Wraps;
    logic       Overflow;
    logic       Locked;
    logic       Error;

    gray_rx_monitor #(.WIDTH(3), .WRAP_W(4)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Valid    (Valid),
        .GrayIn   (GrayIn),
        .Resync   (Resync),
        .BinOut   (BinOut),
        .Step     (Step),
        .Wraps    (Wraps),
        .Overflow (Overflow),
        .Locked   (Locked),
        .Error    (Error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int bin;
        int step;
        int wraps;
        int ovf;
        int locked;
        int err;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    // reference model: 0 = unlock, 1 = lock, 2 = fault
    int m_state, m_bin, m_step, m_wraps, m_ovf;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    function automatic int gdec(input logic [2:0] g);
        int b = 0;
        for (int i = 0; i < 3; i++) b = b ^ (int'(g) >> i);
        return b & 7;
    endfunction

    task automatic model_reset();
        m_state = 0; m_bin = 0; m_step = 0; m_wraps = 0; m_ovf = 0;
    endtask

    task automatic model_step(input logic v, input logic [2:0] g, input logic rs);
        int d;
        d = gdec(g);
        m_step = 0;
        if (rs) begin
            m_state = 0;
        end else if (v) begin
            if (m_state == 0) begin
                m_bin = d;
                m_state = 1;
            end else if (m_state == 1 && d != m_bin) begin
                if (d == ((m_bin + 1) % 8)) begin
                    if (m_bin == 7) begin
                        m_ovf = 1;
                        if (m_wraps < 15) m_wraps++;
                    end
                    m_bin = d;
                    m_step = 1;
                end else begin
                    m_state = 2;
                end
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [2:0] g, input logic rs);
        exp_t e;
        @(negedge Clk);
        Valid = v; GrayIn = g; Resync = rs;
        model_step(v, g, rs);
        e.bin = m_bin; e.step = m_step; e.wraps = m_wraps; e.ovf = m_ovf;
        e.locked = (m_state == 1); e.err = (m_state == 2);
        sb.push_back(e);
        @(posedge Clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("sb_bin",    int'(BinOut),   e.bin);
            check("sb_step",   int'(Step),     e.step);
            check("sb_wraps",  int'(Wraps),    e.wraps);
            check("sb_ovf",    int'(Overflow), e.ovf);
            check("sb_locked", int'(Locked),   e.locked);
            check("sb_err",    int'(Error),    e.err);
        end
        @(negedge Clk);
        Valid = 1'b0; Resync = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bin"},    int'(BinOut),   0);
        check({tag, "_step"},   int'(Step),     0);
        check({tag, "_wraps"},  int'(Wraps),    0);
        check({tag, "_ovf"},    int'(Overflow), 0);
        check({tag, "_locked"}, int'(Locked),   0);
        check({tag, "_err"},    int'(Error),    0);
    endtask

    logic [2:0] gseq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    initial begin
        Reset = 1'b1; Valid = 1'b0; GrayIn = '0; Resync = 1'b0;
        model_reset();
        #12;
        check_all_zero("rst");
        @(negedge Clk);
        Reset = 1'b0;

        // full sequence with wrap
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, gseq[i % 8], 1'b0);
            check("seq_bin", int'(BinOut), i % 8);
            check("seq_step", int'(Step), (i == 0) ? 0 : 1);
            check("seq_locked", int'(Locked), 1);
        end
        check("seq_wraps", int'(Wraps), 1);
        check("seq_ovf", int'(Overflow), 1);

        // mid-stream lock
        do_reset();
        cycle(1'b1, 3'b110, 1'b0);
        check("mid_bin", int'(BinOut), 4);
        check("mid_locked", int'(Locked), 1);
        check("mid_step", int'(Step), 0);
        cycle(1'b1, 3'b111, 1'b0);
        check("mid_bin2", int'(BinOut), 5);
        check("mid_step2", int'(Step), 1);

        // hold across a gap
        do_reset();
        cycle(1'b1, 3'b011, 1'b0);
        cycle(1'b0, 3'b011, 1'b0);
        check("gap_bin", int'(BinOut), 2);
        cycle(1'b1, 3'b011, 1'b0);
        check("hold_bin", int'(BinOut), 2);
        check("hold_step", int'(Step), 0);
        check("hold_err", int'(Error), 0);

        // illegal jump, ignored samples, resync priority, relock
        do_reset();
        cycle(1'b1, 3'b001, 1'b0);
        cycle(1'b1, 3'b010, 1'b0);
        check("jump_err", int'(Error), 1);
        check("jump_locked", int'(Locked), 0);
        check("jump_bin", int'(BinOut), 1);
        cycle(1'b1, 3'b011, 1'b0);
        check("fault_frozen_bin", int'(BinOut), 1);
        check("fault_frozen_err", int'(Error), 1);
        cycle(1'b1, 3'b000, 1'b1);
        check("resync_err", int'(Error), 0);
        check("resync_locked", int'(Locked), 0);
        check("resync_bin", int'(BinOut), 1);
        cycle(1'b1, 3'b000, 1'b0);
        check("relock_bin", int'(BinOut), 0);
        check("relock_locked", int'(Locked), 1);

        // backward step is a fault
        cycle(1'b1, 3'b001, 1'b0);
        cycle(1'b1, 3'b000, 1'b0);
        check("back_err", int'(Error), 1);
        check("back_bin", int'(BinOut), 1);

        // wrap saturation
        do_reset();
        cycle(1'b1, 3'b000, 1'b0);
        for (int w = 1; w <= 17; w++) begin
            for (int k = 1; k <= 8; k++) cycle(1'b1, gseq[k % 8], 1'b0);
            check("sat_wraps", int'(Wraps), (w < 15) ? w : 15);
            check("sat_ovf", int'(Overflow), 1);
        end

        // advance to 5, then pulse async reset between edges
        for (int k = 1; k <= 5; k++) cycle(1'b1, gseq[k], 1'b0);
        check("pre_rst_bin", int'(BinOut), 5);
        check("pre_rst_ovf", int'(Overflow), 1);
        @(posedge Clk);
        #3;
        Reset = 1'b1;
        model_reset();
        #2;
        check_all_zero("async_rst");
        Reset = 1'b0;
        cycle(1'b1, 3'b101, 1'b0);
        check("post_rst_bin", int'(BinOut), 6);
        check("post_rst_locked", int'(Locked), 1);
        check("post_rst_wraps", int'(Wraps), 0);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gray_rx_monitor.md
Name: gray_rx_monitor

Overview:
- Receiving end of the Gray-code counter interface: samples a WIDTH-bit Gray code stream produced by a Gray counter and converts it back to binary.
- Tracks wrap-arounds and flags any illegal transition, meaning anything other than a hold or a single +1 step.
- Sits downstream of a Gray counter, e.g. across a clock-domain boundary after a synchroniser, as a decoder plus integrity checker.

Parameters:
- WIDTH, 3, width of the Gray code and of BinOut.
- WRAP_W, 4, width of the saturating wrap counter Wraps.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Valid  input  1  GrayIn is sampled on a rising edge where Valid=1.
- GrayIn  input  WIDTH  incoming Gray code.
- Resync  input  1  synchronous re-lock request; clears the fault.
- BinOut  output  WIDTH  binary value of the last accepted code (registered).
- Step  output  1  one-cycle pulse when an accepted code advanced by +1.
- Wraps  output  WRAP_W  count of max->0 wraps; saturates at all-ones.
- Overflow  output  1  sticky; set on the first wrap.
- Locked  output  1  high in LOCK state.
- Error  output  1  sticky; high in FAULT state.

Behaviour:
- Reset: asynchronous and active-high; the clock is Clk and the reset is Reset.
  - While Reset=1, all outputs are 0 immediately, independent of Clk, and state=UNLOCK.
  - Deassertion takes effect at the next edge.
- Outputs: all registered; latency is 1 cycle from the sampling edge to the output.
- Decode: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i]. Purely combinational; the decoded value is registered into BinOut.
- Step: defaults to 0 every cycle; it is 1 only in the cycle after an advance.
- UNLOCK state:
  - Valid=1: BinOut <= decode(GrayIn), Locked <= 1, go to LOCK.
  - The first code is always accepted. Step stays 0 and Wraps is unchanged.
- LOCK state, on Valid=1, with d = decode(GrayIn):
  - d == BinOut: hold. No change, Step=0.
  - d == BinOut+1 modulo 2^WIDTH: advance. BinOut <= d, Step <= 1.
    - If BinOut was all-ones (wrap): Wraps <= Wraps+1, saturating at 2^WRAP_W-1, and Overflow <= 1.
  - Any other d: go to FAULT. Error <= 1, Locked <= 0; BinOut, Wraps and Overflow hold their last good values.
- FAULT state:
  - Valid samples are ignored; outputs are frozen.
  - Exit only via Resync or Reset.
- Resync=1 at an edge, in any state:
  - Go to UNLOCK; Error <= 0, Locked <= 0, Step <= 0.
  - BinOut, Wraps and Overflow are retained.
  - Resync has priority over a simultaneous Valid; that sample is discarded.
- Valid=0: no state change; Step returns to 0.
- Backward step (d == BinOut-1) is a FAULT; the counter only counts up.
- Overflow and Wraps are cleared only by Reset.
- States use a one-hot or 2-bit encoding; no illegal-state lockup is permitted (default branch goes to UNLOCK).

Decomposition:
- Package gray_pkg:
  - state encodings ST_UNLOCK=2'b00, ST_LOCK=2'b01, ST_FAULT=2'b10;
  - g2b function parameterised by WIDTH.
- Sub-module gray2bin: combinational decoder (WIDTH parameter), instantiated once on GrayIn.

Test Plan:
- Reset, then Valid each cycle with GrayIn = 000,001,011,010,110,111,101,100,000 -> BinOut = 0,1,2,3,4,5,6,7,0. Locked=1 after the first sample. Step=1 on the last 8 samples. After the final sample, Wraps=1 and Overflow=1.
- Mid-stream lock: the first Valid has GrayIn=110 -> BinOut=4, Locked=1, Step=0. Next GrayIn=111 -> BinOut=5, Step=1.
- Hold and gaps: GrayIn=011 on two consecutive Valid cycles, with a Valid=0 cycle between them -> BinOut=2 throughout, Step=0, Error=0.
- Illegal jump: after lock at 001, GrayIn=010 (bin 3) -> Error=1, Locked=0, BinOut stays 1. Further Valid is ignored. Resync=1 together with Valid, GrayIn=000 -> Error=0, Locked=0, BinOut=1. The next Valid with 000 -> BinOut=0, Locked=1.
- Wrap saturation (WRAP_W=4): drive 17 full cycles of the sequence -> Wraps=15 after the 15th wrap and stays 15. Overflow=1 from the first wrap.
- Asynchronous reset: assert Reset for 2 ns between clock edges while BinOut=5 and Overflow=1 -> all outputs 0 before the next edge. After release, the first Valid relocks.
